// File: rtl/phase_sequencer.sv
// phase_sequencer: byte-serial instruction fetch, decode and phased ALU strobes.
// Each instruction is fetched one byte at a time. DECODE is revisited after
// every byte until the full length is present. The instruction then steps
// through its ALU phases (EX4/EX6/EX8), and WB pulses the register write.
// Unknown opcodes and HLT park the sequencer in HALT until reset.
module phase_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_data_i,
    output logic        mem_req_o,
    output logic        pc_inc_o,
    output logic [31:0] ope_o,
    output logic [3:0]  num_of_ope_o,
    output logic [2:0]  alu_phase_o,
    output logic        mem_we_o,
    output logic        reg_we_o,
    output logic        halted_o,
    output logic        illegal_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EX4    = 3'd3,
        EX6    = 3'd4,
        EX8    = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } state_t;

    localparam logic [7:0] OP_PUSH = 8'h55;  // push ebp
    localparam logic [7:0] OP_POP  = 8'h5d;  // pop ebp
    localparam logic [7:0] OP_RET  = 8'hc3;  // ret
    localparam logic [7:0] OP_HLT  = 8'hf4;  // hlt
    localparam logic [7:0] OP_MOVR = 8'h89;  // mov r/m, r
    localparam logic [7:0] OP_LOOP = 8'he2;  // loop rel8
    localparam logic [7:0] OP_MOVI = 8'hb8;  // mov eax, imm24

    // Instruction length in bytes. Zero marks an opcode that is not recognised.
    function automatic logic [3:0] op_len(input logic [7:0] op);
        case (op)
            OP_PUSH, OP_POP, OP_RET, OP_HLT: op_len = 4'd1;
            OP_MOVR:                         op_len = 4'd2;
            OP_LOOP:                         op_len = 4'd3;
            OP_MOVI:                         op_len = 4'd4;
            default:                         op_len = 4'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;          // next byte slot to fill (0..4)
    logic [31:0] ope_q, ope_d;
    logic [3:0]  nope_q, nope_d;
    logic        illegal_q, illegal_d;
    logic        mem_req_q, pc_unused_q;
    logic [2:0]  alu_phase_q;
    logic        mem_we_q, reg_we_q, halted_q;
    logic        accept;
    logic [7:0]  opcode;
    logic [3:0]  dec_len;

    assign opcode  = ope_q[31:24];
    assign dec_len = op_len(opcode);
    // A byte is consumed only while a request is actually outstanding.
    assign accept  = mem_req_q & mem_ready_i;

    // Next-state and datapath update for fetch, decode and phase sequencing.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ope_d     = ope_q;
        nope_d    = nope_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (run_i) begin
                    state_d = FETCH;
                    k_d     = 3'd0;
                end
            end
            FETCH: begin
                if (accept) begin
                    // Byte 0 wipes the operand bytes left from the previous instruction.
                    case (k_q[1:0])
                        2'd0:    ope_d = {mem_data_i, 24'h0};
                        2'd1:    ope_d[23:16] = mem_data_i;
                        2'd2:    ope_d[15:8]  = mem_data_i;
                        default: ope_d[7:0]   = mem_data_i;
                    endcase
                    k_d     = k_q + 3'd1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                nope_d = dec_len;
                if (dec_len == 4'd0) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else if (opcode == OP_HLT) begin
                    state_d = HALT;
                end else if ({1'b0, k_q} < dec_len) begin
                    state_d = FETCH;
                end else begin
                    state_d = EX4;
                end
            end
            EX4:     state_d = (opcode == OP_MOVR) ? WB : EX6;
            EX6:     state_d = (opcode == OP_LOOP) ? EX8 : WB;
            EX8:     state_d = WB;
            WB: begin
                k_d     = 3'd0;
                state_d = run_i ? FETCH : IDLE;
            end
            default: state_d = HALT;  // HALT is absorbing
        endcase
    end

    // State, datapath and registered strobes; strobes are decoded from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            ope_q       <= 32'h0;
            nope_q      <= 4'd0;
            illegal_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            alu_phase_q <= 3'b000;
            mem_we_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            halted_q    <= 1'b0;
            pc_unused_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            ope_q       <= ope_d;
            nope_q      <= nope_d;
            illegal_q   <= illegal_d;
            mem_req_q   <= (state_d == FETCH);
            alu_phase_q <= {state_d == EX8, state_d == EX6, state_d == EX4};
            mem_we_q    <= (state_d == EX6) && (ope_d[31:24] == OP_PUSH);
            reg_we_q    <= (state_d == WB);
            halted_q    <= (state_d == HALT);
            pc_unused_q <= 1'b0;
        end
    end

    assign mem_req_o    = mem_req_q;
    // pc_inc must coincide with the accepting cycle, so it is a gated copy of the handshake.
    assign pc_inc_o     = accept | pc_unused_q;
    assign ope_o        = ope_q;
    assign num_of_ope_o = nope_q;
    assign alu_phase_o  = alu_phase_q;
    assign mem_we_o     = mem_we_q;
    assign reg_we_o     = reg_we_q;
    assign halted_o     = halted_q;
    assign illegal_o    = illegal_q;

    // Structural invariants of the strobes.
    a_phase_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(alu_phase_o));
    a_halt_quiet   : assert property (@(posedge clk_i) disable iff (rst_i)
                                      halted_o |-> !(mem_req_o || reg_we_o || mem_we_o));
    a_we_in_ex6    : assert property (@(posedge clk_i) disable iff (rst_i) mem_we_o |-> alu_phase_o[1]);

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a cycle trace is assembled from instruction-level
// rules (byte count, wait cycles, phase count), then replayed into the DUT
// and compared cycle by cycle.
module tb_phase_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  data = 8'h0;
    logic        mem_req, pc_inc, mem_we, reg_we, halted, illegal;
    logic [31:0] ope;
    logic [3:0]  nope;
    logic [2:0]  ph;

    always #5 clk = ~clk;

    phase_sequencer dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .mem_ready_i(rdy), .mem_data_i(data),
        .mem_req_o(mem_req), .pc_inc_o(pc_inc), .ope_o(ope), .num_of_ope_o(nope),
        .alu_phase_o(ph), .mem_we_o(mem_we), .reg_we_o(reg_we), .halted_o(halted),
        .illegal_o(illegal)
    );

    typedef struct packed {
        logic        rst, run, rdy;
        logic [7:0]  data;
        logic        req, inc;
        logic [2:0]  ph;
        logic        mw, rw, halt, ill;
        logic [31:0] ope;
        logic [3:0]  n;
    } cyc_t;

    cyc_t        tr[$];
    logic [31:0] m_ope = 32'h0;
    logic [3:0]  m_n = 4'h0;
    bit          m_idle = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    function automatic int op_len(input logic [7:0] op);
        case (op)
            8'h55, 8'h5d, 8'hc3, 8'hf4: return 1;
            8'h89: return 2;
            8'he2: return 3;
            8'hb8: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void push(input logic r, input logic rn, input logic rd, input logic [7:0] d,
                                 input logic req, input logic inc, input logic [2:0] p,
                                 input logic mw, input logic rw, input logic hl, input logic il);
        cyc_t e;
        e = '{rst: r, run: rn, rdy: rd, data: d, req: req, inc: inc, ph: p, mw: mw, rw: rw,
              halt: hl, ill: il, ope: m_ope, n: m_n};
        tr.push_back(e);
    endfunction

    function automatic void reset_cycle();
        m_ope  = 32'h0;
        m_n    = 4'h0;
        m_idle = 1'b1;
        push(1, rb(), rb(), rbyte(), 0, 0, 3'b000, 0, 0, 0, 0);
    endfunction

    // Append one instruction: optional idle gap, byte fetches with waits, phases, WB or HALT.
    // ww holds one wait-count nibble per byte, byte 0 in the top nibble.
    function automatic void build(input logic [31:0] bw, input logic [15:0] ww, input bit run_after,
                                  input int gap, output int fst, output int acc0, output int rwi);
        logic [7:0] op;
        int len, nb, phs, hc;
        op   = bw[31:24];
        len  = op_len(op);
        nb   = (len == 0) ? 1 : len;
        acc0 = -1;
        rwi  = -1;
        if (m_idle) begin
            for (int i = 0; i < gap; i++) push(0, 0, rb(), rbyte(), 0, 0, 3'b000, 0, 0, 0, 0);
            push(0, 1, rb(), rbyte(), 0, 0, 3'b000, 0, 0, 0, 0);
        end
        fst = tr.size();
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < int'(ww[15-4*i -: 4]); j++)
                push(0, rb(), 0, rbyte(), 1, 0, 3'b000, 0, 0, 0, 0);
            if (i == 0) acc0 = tr.size();
            push(0, rb(), 1, bw[31-8*i -: 8], 1, 1, 3'b000, 0, 0, 0, 0);
            if (i == 0) m_ope = {op, 24'h0};
            else        m_ope[31-8*i -: 8] = bw[31-8*i -: 8];
            push(0, rb(), rb(), rbyte(), 0, 0, 3'b000, 0, 0, 0, 0);  // decode
            m_n = 4'(len);
        end
        if (len == 0 || op == 8'hf4) begin
            hc = 3 + int'($urandom_range(0, 3));
            for (int i = 0; i < hc; i++)
                push(0, rb(), rb(), rbyte(), 0, 0, 3'b000, 0, 0, 1, len == 0);
            reset_cycle();
            return;
        end
        phs = (op == 8'h89) ? 1 : (op == 8'he2) ? 3 : 2;
        push(0, rb(), rb(), rbyte(), 0, 0, 3'b001, 0, 0, 0, 0);
        if (phs >= 2) push(0, rb(), rb(), rbyte(), 0, 0, 3'b010, op == 8'h55, 0, 0, 0);
        if (phs == 3) push(0, rb(), rb(), rbyte(), 0, 0, 3'b100, 0, 0, 0, 0);
        rwi = tr.size();
        push(0, run_after, rb(), rbyte(), 0, 0, 3'b000, 0, 1, 0, 0);
        m_idle = !run_after;
    endfunction

    // Discard everything from index idx on and replace it with a reset cycle.
    function automatic void abort_at(input int idx);
        while (tr.size() > idx) void'(tr.pop_back());
        reset_cycle();
    endfunction

    function automatic void pin(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: model gives %h, hand value %h", nm, got, exp);
        end
    endfunction

    function automatic int count_inc(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += int'(tr[i].inc);
        return s;
    endfunction

    task automatic check(input int c);
        cyc_t e;
        logic [44:0] got, exp;
        e   = tr[c];
        got = {mem_req, pc_inc, ph, mem_we, reg_we, halted, illegal, ope, nope};
        exp = {e.req, e.inc, e.ph, e.mw, e.rw, e.halt, e.ill, e.ope, e.n};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL cyc%0d: got req=%b inc=%b ph=%b mw=%b rw=%b halt=%b ill=%b ope=%h n=%0d; want req=%b inc=%b ph=%b mw=%b rw=%b halt=%b ill=%b ope=%h n=%0d",
                     c, mem_req, pc_inc, ph, mem_we, reg_we, halted, illegal, ope, nope,
                     e.req, e.inc, e.ph, e.mw, e.rw, e.halt, e.ill, e.ope, e.n);
        end
    endtask

    initial begin
        int f, a, w, r, s0;
        logic [7:0] op;
        logic [7:0] legal[6];
        logic [15:0] ww;
        legal = '{8'h55, 8'h5d, 8'hc3, 8'h89, 8'he2, 8'hb8};

        reset_cycle();

        // push ebp, no waits
        build(32'h55000000, 16'h0000, 1, 2, f, a, w);
        pin("lat_55", 32'(w - a), 32'd4);
        pin("ope_55", tr[w].ope, 32'h55000000);
        pin("n_55", 32'(tr[w].n), 32'd1);
        pin("inc_55", 32'(count_inc(a, w)), 32'd1);
        pin("we_55", {28'h0, tr[a+3].ph, tr[a+3].mw}, 32'h5);

        // mov eax, imm with two wait cycles on byte 2
        build(32'hb8112233, 16'h0020, 0, 0, f, a, w);
        pin("lat_b8", 32'(w - a), 32'd12);
        pin("ope_b8", tr[w].ope, 32'hb8112233);
        pin("n_b8", 32'(tr[w].n), 32'd4);
        pin("inc_b8", 32'(count_inc(a, w)), 32'd4);
        pin("wait_b8", {30'h0, tr[a+5].req, tr[a+5].inc}, 32'h2);

        // loop rel8: three phases
        build(32'he2eeff00, 16'h0000, 1, 1, f, a, w);
        pin("lat_e2", 32'(w - a), 32'd9);
        pin("ope_e2", tr[w].ope, 32'he2eeff00);
        pin("ph8_e2", 32'(tr[a+8].ph), 32'h4);

        build(32'h89aa0000, 16'h0000, 0, 0, f, a, w);
        pin("lat_89", 32'(w - a), 32'd5);
        pin("ope_89", tr[w].ope, 32'h89aa0000);

        // pop ebp, reset lands on EX6
        build(32'h5d000000, 16'h0000, 1, 1, f, a, w);
        pin("ex6_5d", 32'(tr[a+3].ph), 32'h2);
        abort_at(a + 3);

        // hlt: halts cleanly, no writeback
        s0 = tr.size();
        build(32'hf4000000, 16'h0000, 1, 0, f, a, w);
        pin("halt_f4", {30'h0, tr[a+2].halt, tr[a+2].ill}, 32'h2);
        r = 0;
        for (int i = s0; i < tr.size(); i++) r += int'(tr[i].rw);
        pin("norw_f4", 32'(r), 32'd0);

        // unknown opcode 00
        build(32'h00000000, 16'h0000, 1, 0, f, a, w);
        pin("halt_00", {29'h0, tr[a+2].req, tr[a+2].halt, tr[a+2].ill}, 32'h3);

        // randomized instruction stream
        for (int n = 0; n < 180; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 17) op = legal[r % 6];
            else if (r == 17) op = 8'hf4;
            else begin
                op = rbyte();
                while (op_len(op) != 0) op = rbyte();
            end
            ww = 16'h0;
            for (int i = 0; i < 4; i++)
                if (rb()) ww[15-4*i -: 4] = 4'($urandom_range(1, 3));
            build({op, 24'($urandom)}, ww, rb(), int'($urandom_range(0, 3)), f, a, w);
            if (w >= 0 && $urandom_range(0, 9) == 0)
                abort_at(f + int'($urandom_range(0, w - f)));
        end
        push(0, 0, 0, 8'h0, 0, 0, 3'b000, 0, 0, 0, 0);

        // Replay: inputs at the falling edge, outputs checked 1 ns later.
        for (int c = 0; c < tr.size(); c++) begin
            @(negedge clk);
            rst  = tr[c].rst;
            run  = tr[c].run;
            rdy  = tr[c].rdy;
            data = tr[c].data;
            #1;
            check(c);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
